// File: rtl/input_sram_ctrl_pkg.sv
// Shared constants and FSM state type for the input image SRAM controller.
package input_sram_pkg;
  localparam int DEPTH = 784;            // words per 28x28 image
  localparam int DW    = 16;             // pixel / SRAM word width
  localparam int AW    = 16;             // SRAM address width
  localparam int CNT_W = $clog2(DEPTH);  // write counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;
endpackage

// File: rtl/input_sram_ctrl_if.sv
// Pixel stream, consumer read port and SRAM bus grouped as one bundle.
// slave: the controller side; master: the producer/consumer/SRAM side.
interface input_sram_ctrl_if #(
  parameter int DW = input_sram_pkg::DW,
  parameter int AW = input_sram_pkg::AW
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_write;
  logic [DW-1:0] sram_wdata;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  in_valid, in_data, rd_req, rd_addr, sram_rdata,
    output in_ready, rd_gnt, rd_valid, rd_data, sram_write, sram_wdata, sram_address
  );

  modport master (
    output in_valid, in_data, rd_req, rd_addr, sram_rdata,
    input  in_ready, rd_gnt, rd_valid, rd_data, sram_write, sram_wdata, sram_address
  );
endinterface

// File: rtl/input_sram_ctrl.sv
// Input image SRAM controller: loads one image from a pixel stream into an
// external single-port SRAM, then serves single-cycle-latency reads.
// Optional: INPUT_SRAM_CTRL_ADDR_CHECK_EN adds rd_err and rejects
// out-of-range read addresses.
module input_sram_ctrl #(
  parameter int DEPTH = input_sram_pkg::DEPTH,
  parameter int DW    = input_sram_pkg::DW,
  parameter int AW    = input_sram_pkg::AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               load_done,
`ifdef INPUT_SRAM_CTRL_ADDR_CHECK_EN
  output logic               rd_err,
`endif
  input_sram_ctrl_if.slave   bus
);
  import input_sram_pkg::*;

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic          cnt_clr, cnt_inc, done_set, done_clr;
  logic          err_nxt;

  // State register, write counter, load_done flag and read-response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      load_done     <= 1'b0;
      bus.rd_valid  <= 1'b0;
`ifdef INPUT_SRAM_CTRL_ADDR_CHECK_EN
      rd_err        <= 1'b0;
`endif
    end else begin
      state        <= nstate;
      bus.rd_valid <= bus.rd_gnt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (done_clr)      load_done <= 1'b0;
      else if (done_set) load_done <= 1'b1;
`ifdef INPUT_SRAM_CTRL_ADDR_CHECK_EN
      rd_err <= err_nxt;
`endif
    end
  end

  // Next state and all SRAM/handshake outputs; outside LOAD the SRAM
  // address follows the consumer's rd_addr and write data is held at 0.
  always_comb begin
    nstate           = state;
    bus.in_ready     = 1'b0;
    bus.rd_gnt       = 1'b0;
    bus.sram_write   = 1'b0;
    bus.sram_wdata   = '0;
    bus.sram_address = bus.rd_addr;
    cnt_clr          = 1'b0;
    cnt_inc          = 1'b0;
    done_set         = 1'b0;
    done_clr         = 1'b0;
    err_nxt          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nstate   = LOAD;
          cnt_clr  = 1'b1;
          done_clr = 1'b1;
        end
      end
      LOAD: begin
        bus.in_ready     = 1'b1;
        bus.sram_address = AW'(cnt);
        if (bus.in_valid) begin
          bus.sram_write = 1'b1;
          bus.sram_wdata = bus.in_data;
          cnt_inc        = 1'b1;
          if (cnt == LAST) begin
            nstate   = SERVE;
            done_set = 1'b1;
          end
        end
      end
      SERVE: begin
        if (start) begin
          // Reload pre-empts this cycle's read; a read granted last cycle
          // still completes through the rd_valid register.
          nstate   = LOAD;
          cnt_clr  = 1'b1;
          done_clr = 1'b1;
        end else begin
`ifdef INPUT_SRAM_CTRL_ADDR_CHECK_EN
          if ({1'b0, bus.rd_addr} >= (AW+1)'(DEPTH)) begin
            bus.sram_address = '0;
            err_nxt          = bus.rd_req;
          end else begin
            bus.rd_gnt = bus.rd_req;
          end
`else
          bus.rd_gnt = bus.rd_req;
`endif
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Read data comes straight from the SRAM's registered output.
  assign bus.rd_data = bus.sram_rdata;

`ifndef INPUT_SRAM_CTRL_ADDR_CHECK_EN
  logic unused_err;
  assign unused_err = err_nxt;
`endif
endmodule

// File: doc/input_sram_ctrl.md
INPUT_SRAM_CTRL -- requirements
Module: input_sram_ctrl

Interface
REQ-001 Parameter DEPTH, default 784, words per image (28x28 pixels).
REQ-002 Parameter DW, default 16, data width in bits.
REQ-003 Parameter AW, default 16, SRAM address width in bits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins loading a new image.
REQ-007 in_valid  in  1  / in_ready  out  1  / in_data  in  DW  pixel stream handshake.
REQ-008 load_done  out  1  level signal; a full image is resident in SRAM.
REQ-009 rd_req  in  1  / rd_addr  in  AW  consumer read request and word address.
REQ-010 rd_gnt  out  1  read accepted this cycle.
REQ-011 rd_valid  out  1  / rd_data  out  DW  read response.
REQ-012 rd_err  out  1  out-of-range read flag; present only when the macro in REQ-030 is defined.
REQ-013 sram_write  out  1  / sram_wdata  out  DW  / sram_address  out  AW  / sram_rdata  in  DW  drive the single-port synchronous SRAM (sram_input), which has 1-cycle read latency and writes when sram_write=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, LOAD and SERVE.
REQ-015 IDLE: in_ready=0, rd_gnt=0, sram_write=0; start -> LOAD with the write counter cleared to 0 and load_done cleared to 0.
REQ-016 LOAD: in_ready=1; each beat with in_valid=1 SHALL combinationally drive sram_write=1, sram_address=counter, sram_wdata=in_data, and SHALL increment the counter.
REQ-017 LOAD: an accepted beat at counter=DEPTH-1 SHALL move the FSM to SERVE and set load_done=1 on the next cycle. A beat at any other count SHALL keep the FSM in LOAD.
REQ-018 LOAD: rd_req SHALL be ignored (rd_gnt=0), and start SHALL be ignored.
REQ-019 SERVE: in_ready=0 and sram_write=0; rd_gnt=rd_req combinationally, with sram_address=rd_addr.
REQ-020 rd_valid SHALL be rd_gnt registered one cycle; rd_data SHALL be sram_rdata passed through unregistered. Read latency is 1 cycle, and one read per cycle is sustained back-to-back.
REQ-021 SERVE with start=1: the FSM SHALL go to LOAD, clear the counter, clear load_done next cycle, and give rd_gnt=0 that cycle. A read granted in the prior cycle SHALL still produce its rd_valid.
REQ-022 Counter width SHALL be ceil(log2(DEPTH)). It never wraps: it is cleared only by start or reset.
REQ-023 When not in LOAD, sram_address SHALL equal rd_addr and sram_wdata SHALL be 0.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, counter=0, load_done=0, rd_valid=0 and rd_err=0.
REQ-025 A reset during LOAD SHALL abort the load, and load_done SHALL remain 0 until a complete reload.
REQ-026 SRAM contents are not cleared by reset.
REQ-027 Outputs in_ready, rd_gnt and sram_write SHALL be 0 while rst_n=0.

Configuration
REQ-028 Exactly one optional feature SHALL exist, selected by macro INPUT_SRAM_CTRL_ADDR_CHECK_EN.
REQ-029 Without INPUT_SRAM_CTRL_ADDR_CHECK_EN, there is no rd_err port, and any rd_addr SHALL be granted and passed through unchecked.
REQ-030 With INPUT_SRAM_CTRL_ADDR_CHECK_EN, in SERVE an rd_addr >= DEPTH SHALL give rd_gnt=0 and sram_address held at 0. rd_err SHALL pulse for one cycle on the next cycle, and no rd_valid SHALL be produced.

Structure
REQ-031 Package input_sram_pkg SHALL hold DEPTH, DW, AW, the counter width constant and the state enum {IDLE, LOAD, SERVE}.
REQ-032 No sub-module SHALL be used. sram_input is instantiated by the parent alongside this block, not inside it.

Verification
REQ-033 Reset, start, then stream 784 beats 0x0000..0x030F with in_valid always high -> 784 writes at addresses 0..783, load_done=1 exactly one cycle after the last beat.
REQ-034 Load with random in_valid gaps -> no write on gap cycles; SRAM contents equal the stream in order.
REQ-035 In SERVE, rd_req held high with rd_addr 0,1,2,783 on consecutive cycles -> rd_valid high 4 consecutive cycles with data 0x0000,0x0001,0x0002,0x030F.
REQ-036 Deassert rst_n at beat 400 of a load -> IDLE, load_done=0; start and a full reload -> load_done=1.
REQ-037 start in SERVE while a read is granted -> that read's rd_valid still fires, rd_gnt=0 thereafter, load_done falls next cycle.
REQ-038 With INPUT_SRAM_CTRL_ADDR_CHECK_EN, rd_addr=784 -> rd_gnt=0, rd_err=1 one cycle later, rd_valid=0.
